// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: 720p raster timing generator that requests pixels from an upstream source and drives rgb2dvi.
// Latency: pix_req/h_pos/v_pos are combinational from the counters; vid_* appear PIPE_LAT+1 cycles after the raw raster.
// Backpressure: none; the source must return pix_data exactly PIPE_LAT cycles after pix_req, and the raster never stalls.
// Ports: PixelClk/aRst clock and async active-high reset; en level run request; pix_req/h_pos/v_pos pixel request;
//        pix_data source RGB888; vid_pData/vid_pVDE/vid_pHSync/vid_pVSync to rgb2dvi; frame_start pulse; busy status.
module video_timing_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1,
    parameter int PIPE_LAT = 2
) (
    input  logic        PixelClk,
    input  logic        aRst,
    input  logic        en,
    output logic        pix_req,
    output logic [10:0] h_pos,
    output logic [9:0]  v_pos,
    input  logic [23:0] pix_data,
    output logic [23:0] vid_pData,
    output logic        vid_pVDE,
    output logic        vid_pHSync,
    output logic        vid_pVSync,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG_C = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_C = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        h_last, v_last, running;
    logic        act, hs, vs, fs;

    assign h_last  = (hcnt_q == H_LAST_C);
    assign v_last  = (vcnt_q == V_LAST_C);
    assign running = (state_q != ST_IDLE);

    // Counters only move while running; leaving IDLE starts from (0,0) on the following cycle.
    // In DRAIN a raised en wins over the end-of-frame exit so re-enabling never leaves a gap.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en) state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                if (h_last) begin
                    hcnt_d = '0;
                    vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
                end else begin
                    hcnt_d = hcnt_q + 11'd1;
                end
                if (en)                      state_d = ST_RUN;
                else if (state_q == ST_RUN)  state_d = ST_DRAIN;
                else if (h_last && v_last)   state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // Raw raster flags for the current counter cycle.
    assign act = running && (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    assign hs  = running && (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
    assign vs  = running && (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
    assign fs  = running && (hcnt_q == 11'd0) && (vcnt_q == 10'd0);

    assign pix_req = act;
    assign h_pos   = act ? hcnt_q : '0;
    assign v_pos   = act ? vcnt_q : '0;
    assign busy    = running;

    // Flag delay line matching the source read latency; it shifts even in IDLE so the
    // tail of a finished frame still reaches the outputs.
    logic [3:0] raw_flags;
    logic [3:0] tap;
    logic [3:0] dly_q [PIPE_LAT];

    assign raw_flags = {act, hs, vs, fs};
    assign tap       = dly_q[PIPE_LAT-1];

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            for (int i = 0; i < PIPE_LAT; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= raw_flags;
            for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    logic [23:0] data_q;
    logic        vde_q, hsync_q, vsync_q, fs_q;

    // Output register: pix_data is only captured when the delayed flag says it is a real pixel.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            data_q  <= '0;
            vde_q   <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            fs_q    <= 1'b0;
        end else begin
            data_q  <= tap[3] ? pix_data : 24'h0;
            vde_q   <= tap[3];
            hsync_q <= tap[2] ? SYNC_POL : ~SYNC_POL;
            vsync_q <= tap[1] ? SYNC_POL : ~SYNC_POL;
            fs_q    <= tap[0];
        end
    end

    assign vid_pData   = data_q;
    assign vid_pVDE    = vde_q;
    assign vid_pHSync  = hsync_q;
    assign vid_pVSync  = vsync_q;
    assign frame_start = fs_q;

endmodule
